// File: rtl/flash_cmd_arbiter.sv
// flash_cmd_arbiter
//   Round-robin arbiter sharing one SPI-flash command sequencer among NREQ
//   requesters. Only one operation is in flight at a time. Completion is
//   detected when the sequencer state returns to idle (0). Acknowledge and
//   operation watchdogs report timeouts through err. A hung sequencer raises
//   fault until it returns to idle.
// Ports:
//   CLK, RSTn      clock, asynchronous active-low reset
//   req            level request per requester
//   req_op         2-bit op per requester (0 RDID, 1 WRITE, 2 READ, 3 ERASE)
//   gnt            one-hot grant, held for the whole operation
//   done, err      1-cycle completion / timeout pulses to the owner
//   fault          high while a timed-out operation has not returned to idle
//   flash_cmd_o    one-hot command to the sequencer, asserted only in ISSUE
//   flash_state_i  sequencer state, 0 = idle
module flash_cmd_arbiter #(
  parameter int unsigned       NREQ    = 2,
  parameter int unsigned       TMO_W   = 24,
  parameter logic [TMO_W-1:0]  ACK_TMO = TMO_W'(16),
  parameter logic [TMO_W-1:0]  OP_TMO  = 24'd5_000_000
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_op,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [NREQ-1:0]     err,
  output logic                fault,
  output logic [3:0]          flash_cmd_o,
  input  logic [3:0]          flash_state_i
);

  localparam int unsigned      OW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TMO_W-1:0] ACK_LAST = ACK_TMO - TMO_W'(1);
  localparam logic [TMO_W-1:0] OP_LAST  = OP_TMO - TMO_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HANG} state_t;

  state_t           state;
  logic [3:0]       st_q;
  logic [OW-1:0]    rr_ptr;
  logic [OW-1:0]    owner;
  logic [TMO_W-1:0] timer;
  logic [TMO_W-1:0] timer_inc;
  logic [OW-1:0]    win;
  logic [1:0]       win_op;

  // First set request searching upward from p+1, wrapping modulo NREQ.
  // Iterating from the farthest candidate down lets the nearest one win.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [OW-1:0]   p);
    logic [OW-1:0] w;
    logic [OW-1:0] idx;
    w = p;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      idx = OW'((32'(p) + k) % NREQ);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  always_comb begin
    win       = rr_pick(req, rr_ptr);
    win_op    = req_op[{win, 1'b0} +: 2];
    timer_inc = (timer == '1) ? timer : timer + TMO_W'(1);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      st_q        <= '0;
      rr_ptr      <= OW'(NREQ - 1);
      owner       <= '0;
      timer       <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= '0;
      fault       <= 1'b0;
      flash_cmd_o <= '0;
    end else begin
      st_q <= flash_state_i;
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (st_q == '0 && |req) begin
            owner       <= win;
            gnt         <= NREQ'(1) << win;
            flash_cmd_o <= 4'(1) << win_op;
            timer       <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (st_q != '0) begin
            flash_cmd_o <= '0;
            timer       <= '0;
            state       <= BUSY;
          end else if (timer == ACK_LAST) begin
            err         <= gnt;
            gnt         <= '0;
            flash_cmd_o <= '0;
            rr_ptr      <= owner;
            state       <= IDLE;
          end else begin
            timer <= timer_inc;
          end
        end
        BUSY: begin
          // Sequences never pass through 0 mid-operation: first 0 = finished.
          if (st_q == '0) begin
            done   <= gnt;
            gnt    <= '0;
            rr_ptr <= owner;
            state  <= IDLE;
          end else if (timer == OP_LAST) begin
            err    <= gnt;
            gnt    <= '0;
            fault  <= 1'b1;
            rr_ptr <= owner;
            state  <= HANG;
          end else begin
            timer <= timer_inc;
          end
        end
        HANG: begin
          if (st_q == '0) begin
            fault <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_cmd_arbiter.sv
// tb_flash_cmd_arbiter
//   Directed bench for flash_cmd_arbiter (NREQ=2, ACK_TMO=16, OP_TMO=50).
//   A transaction-level model predicts gnt/done/err/fault/flash_cmd_o and is
//   compared every cycle. Literal expectations on grant order, pulse counts
//   and phase lengths pin the model. Inputs change 1 time unit after the
//   rising edge. Outputs are sampled on the falling edge.
module tb_flash_cmd_arbiter;

  localparam int NREQ = 2;
  localparam int ACK  = 16;
  localparam int OPT  = 50;

  logic              CLK;
  logic              RSTn;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_op;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic              fault;
  logic [3:0]        flash_cmd_o;
  logic [3:0]        flash_state_i;

  flash_cmd_arbiter #(
    .NREQ    (NREQ),
    .TMO_W   (24),
    .ACK_TMO (24'd16),
    .OP_TMO  (24'd50)
  ) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .req           (req),
    .req_op        (req_op),
    .gnt           (gnt),
    .done          (done),
    .err           (err),
    .fault         (fault),
    .flash_cmd_o   (flash_cmd_o),
    .flash_state_i (flash_state_i)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model: one record for the operation in flight ----------
  int              m_own;    // -1 when no operation is owned
  bit              m_acked;  // sequencer has left idle for this operation
  bit              m_hang;   // waiting for a timed-out sequencer to go idle
  int              m_age;    // cycles spent waiting in the current phase
  int              m_last;   // previous owner, for rotation
  logic [3:0]      m_seen;   // sequencer state as seen one cycle late
  logic [NREQ-1:0] e_gnt, e_done, e_err;
  logic            e_fault;
  logic [3:0]      e_cmd;

  initial forever begin
    @(posedge CLK or negedge RSTn);
    if (!RSTn) begin
      m_own = -1; m_acked = 0; m_hang = 0; m_age = 0; m_last = NREQ - 1;
      m_seen = '0; e_gnt = '0; e_done = '0; e_err = '0; e_fault = 0; e_cmd = '0;
    end else begin
      e_done = '0;
      e_err  = '0;
      if (m_hang) begin
        if (m_seen == 0) begin m_hang = 0; e_fault = 0; end
      end else if (m_own < 0) begin
        if (m_seen == 0 && req != 0) begin
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (m_own < 0 && req[c]) m_own = c;
          end
          e_gnt = '0; e_gnt[m_own] = 1'b1;
          e_cmd = 4'b0001 << req_op[2*m_own +: 2];
          m_acked = 0; m_age = 0;
        end
      end else if (!m_acked) begin
        if (m_seen != 0) begin
          m_acked = 1; m_age = 0; e_cmd = '0;
        end else if (m_age + 1 == ACK) begin
          e_err = e_gnt; e_gnt = '0; e_cmd = '0; m_last = m_own; m_own = -1;
        end else m_age++;
      end else begin
        if (m_seen == 0) begin
          e_done = e_gnt; e_gnt = '0; m_last = m_own; m_own = -1;
        end else if (m_age + 1 == OPT) begin
          e_err = e_gnt; e_gnt = '0; e_fault = 1; m_hang = 1; m_last = m_own; m_own = -1;
        end else m_age++;
      end
      m_seen = flash_state_i;
    end
  end

  // ---------------- per-cycle compare ----------------------------------------
  initial forever begin
    @(negedge CLK);
    n_cmp++;
    if (gnt !== e_gnt || done !== e_done || err !== e_err ||
        fault !== e_fault || flash_cmd_o !== e_cmd) begin
      n_bad++;
      $display("FAIL cycle @%0t: gnt=%b/%b done=%b/%b err=%b/%b fault=%b/%b cmd=%b/%b (got/expected)",
               $time, gnt, e_gnt, done, e_done, err, e_err, fault, e_fault, flash_cmd_o, e_cmd);
    end
  end

  // ---------------- activity monitor for literal checks ----------------------
  int              c_gnt, c_cmd, c_done, c_err, c_busy;
  int              g_own[$];
  logic [3:0]      g_cmd[$];
  logic [NREQ-1:0] prev_gnt = '0;

  initial forever begin
    @(negedge CLK);
    if (RSTn) begin
      if (gnt != 0) c_gnt++;
      if (flash_cmd_o != 0) c_cmd++;
      if (done != 0) c_done++;
      if (err != 0) c_err++;
      if (gnt != 0 && flash_cmd_o == 0) c_busy++;
      if (prev_gnt == 0 && gnt != 0) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) g_own.push_back(i);
        g_cmd.push_back(flash_cmd_o);
      end
    end
    prev_gnt = gnt;
  end

  task automatic clr_counts();
    c_gnt = 0; c_cmd = 0; c_done = 0; c_err = 0; c_busy = 0;
    g_own.delete(); g_cmd.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int own_at(input int i);
    return (i < g_own.size()) ? g_own[i] : -1;
  endfunction

  function automatic logic [3:0] cmd_at(input int i);
    return (i < g_cmd.size()) ? g_cmd[i] : 4'hF;
  endfunction

  // Acts as the sequencer: once a command shows, leave idle after lat cycles
  // with state sv and return to idle dur cycles later.
  task automatic serve(input int lat, input int dur, input logic [3:0] sv);
    int n;
    n = 0;
    while (flash_cmd_o == 4'd0 && n < 100) begin tick(1); n++; end
    chk("serve_cmd_seen", 32'(n < 100), 1);
    tick(lat);
    flash_state_i = sv;
    tick(dur);
    flash_state_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    RSTn = 1'b0; req = '0; req_op = '0; flash_state_i = '0;
    clr_counts();
    tick(3);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_cmd", 32'(flash_cmd_o), 0);
    RSTn = 1'b1;
    tick(2);

    // Fairness: both requesters hold req, RDID, 10-cycle operations.
    begin
      int exp_order[4] = '{0, 1, 0, 1};
      clr_counts();
      req = 2'b11; req_op = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        serve(1, 10, 4'h1);
        if (i == 3) req = '0;
      end
      tick(5);
      chk("fair_grants", g_own.size(), 4);
      for (int i = 0; i < 4; i++) chk("fair_order", 32'(own_at(i)), 32'(exp_order[i]));
      chk("fair_done", c_done, 4);
      chk("fair_err", c_err, 0);
    end

    // Single READ by requester 0: idle->4 after 3 cycles, back to 0 after 20.
    clr_counts();
    req = 2'b01; req_op = 4'b0010;
    tick(1); req = '0;
    tick(3); flash_state_i = 4'd4;
    tick(20); flash_state_i = 4'd0;
    tick(4);
    chk("rd_cmd_cycles", c_cmd, 5);
    chk("rd_gnt_cycles", c_gnt, 25);
    chk("rd_done", c_done, 1);
    chk("rd_err", c_err, 0);
    chk("rd_cmd_val", 32'(cmd_at(0)), 4'b0100);

    // Acknowledge timeout: sequencer never leaves idle.
    clr_counts();
    req = 2'b01; req_op = 4'b0000;
    tick(1); req = '0;
    tick(20);
    chk("ack_cmd_cycles", c_cmd, ACK);
    chk("ack_gnt_cycles", c_gnt, ACK);
    chk("ack_err", c_err, 1);
    chk("ack_done", c_done, 0);
    clr_counts();
    req = 2'b10;
    serve(2, 4, 4'h8);
    req = '0;
    tick(4);
    chk("ack_next_owner", 32'(own_at(0)), 1);
    chk("ack_next_done", c_done, 1);

    // Operation timeout: sequencer stuck at 15 while both request.
    clr_counts();
    req = 2'b11; req_op = 4'b0000;
    tick(1);
    tick(1); flash_state_i = 4'd15;
    tick(60);
    chk("op_busy_cycles", c_busy, OPT);
    chk("op_err", c_err, 1);
    chk("op_done", c_done, 0);
    chk("op_grants", g_own.size(), 1);
    chk("op_owner", 32'(own_at(0)), 0);
    chk("op_fault_set", 32'(fault), 1);
    clr_counts();
    flash_state_i = 4'd0;
    tick(3);
    chk("op_fault_clr", 32'(fault), 0);
    serve(1, 5, 4'h1);
    req = '0;
    tick(4);
    chk("op_resume_owner", 32'(own_at(0)), 1);
    chk("op_resume_done", c_done, 1);

    // Request glitch and op change during BUSY.
    clr_counts();
    req = 2'b01; req_op = 4'b0010;
    tick(1); req = '0;
    tick(1); flash_state_i = 4'd4;
    tick(2); req = 2'b10; req_op = 4'b0111;
    tick(8); flash_state_i = 4'd0;
    serve(1, 5, 4'h2);
    req = '0;
    tick(4);
    chk("gl_grants", g_own.size(), 2);
    chk("gl_owner0", 32'(own_at(0)), 0);
    chk("gl_owner1", 32'(own_at(1)), 1);
    chk("gl_cmd0", 32'(cmd_at(0)), 4'b0100);
    chk("gl_cmd1", 32'(cmd_at(1)), 4'b0010);
    chk("gl_done", c_done, 2);

    // Reset during BUSY aborts silently.
    clr_counts();
    req = 2'b01; req_op = 4'b0010;
    tick(1); req = '0;
    tick(1); flash_state_i = 4'd4;
    tick(4);
    RSTn = 1'b0;
    #2;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_fault", 32'(fault), 0);
    chk("mid_rst_cmd", 32'(flash_cmd_o), 0);
    flash_state_i = 4'd0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
    req = 2'b11; req_op = 4'b0000;
    tick(1);
    chk("post_rst_gnt", 32'(gnt), 2'b01);
    req = '0;
    serve(1, 3, 4'h1);
    tick(4);
    chk("post_rst_done", c_done, 1);
    chk("post_rst_err", c_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
